// File: rtl/freq_bcd_formatter.sv
// Sequential double-dabble converter: BIN_WIDTH-bit binary to DIGITS BCD digits, one shift per clock,
// with a registered ASCII character port (leading-zero blanked) for the text overlay.
module freq_bcd_formatter #(
    parameter int BIN_WIDTH = 40,
    parameter int DIGITS    = 13
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic [BIN_WIDTH-1:0]  BIN_IN,
    input  logic [3:0]            DIGIT_SEL,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [4*DIGITS-1:0]   DIGITS_OUT,
    output logic [DIGITS-1:0]     LEAD_MASK,
    output logic [7:0]            CHAR_OUT
);

    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam logic [DIGITS-1:0] MASK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t                state;
    logic [BIN_WIDTH-1:0]  shift_reg;
    logic [4*DIGITS-1:0]   scratch;
    logic [4*DIGITS-1:0]   scratch_adj;
    logic [CNT_W-1:0]      cnt;
    logic [4*DIGITS-1:0]   char_digits;
    logic [DIGITS-1:0]     char_mask;

    function automatic logic [4*DIGITS-1:0] add3_all(input logic [4*DIGITS-1:0] s);
        logic [4*DIGITS-1:0] r;
        logic [3:0]          n;
        r = s;
        for (int i = 0; i < DIGITS; i++) begin
            n = s[4*i +: 4];
            if (n >= 4'd5)
                r[4*i +: 4] = n + 4'd3;
        end
        return r;
    endfunction

    // Bit 0 is never blanked so a zero value still shows a single "0".
    function automatic logic [DIGITS-1:0] lead_mask_of(input logic [4*DIGITS-1:0] d);
        logic [DIGITS-1:0] m;
        logic              z;
        m = '0;
        z = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            z    = z & (d[4*i +: 4] == 4'd0);
            m[i] = z;
        end
        return m;
    endfunction

    function automatic logic [7:0] char_of(input logic [4*DIGITS-1:0] d,
                                           input logic [DIGITS-1:0]   m,
                                           input logic [3:0]          sel);
        logic [7:0] c;
        c = 8'h20;
        for (int i = 0; i < DIGITS; i++) begin
            if (int'(sel) == i && !m[i])
                c = {4'h3, d[4*i +: 4]};
        end
        return c;
    endfunction

    // During COMMIT the character path looks at the value being committed, so a read
    // coinciding with the commit already returns the new digit.
    always_comb begin
        scratch_adj = add3_all(scratch);
        char_digits = DIGITS_OUT;
        char_mask   = LEAD_MASK;
        if (state == COMMIT) begin
            char_digits = scratch;
            char_mask   = lead_mask_of(scratch);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            DIGITS_OUT <= '0;
            LEAD_MASK  <= MASK_RST;
            CHAR_OUT   <= 8'h20;
            shift_reg  <= '0;
            scratch    <= '0;
            cnt        <= '0;
        end else begin
            DONE     <= 1'b0;
            CHAR_OUT <= char_of(char_digits, char_mask, DIGIT_SEL);
            case (state)
                IDLE: begin
                    if (START) begin
                        shift_reg <= BIN_IN;
                        scratch   <= '0;
                        cnt       <= CNT_W'(BIN_WIDTH);
                        BUSY      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    {scratch, shift_reg} <= {scratch_adj, shift_reg} << 1;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        state <= COMMIT;
                end
                COMMIT: begin
                    DIGITS_OUT <= scratch;
                    LEAD_MASK  <= char_mask;
                    DONE       <= 1'b1;
                    BUSY       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
